// File: rtl/digit_sequence_tx.sv
// digit_sequence_tx: sends a stored code one N-bit digit at a time over a
// valid/ready interface. An optional idle gap can follow each accepted digit,
// and a one-cycle done pulse marks the end of the sequence.
// All outputs are registered.
// Optional feature: define DIGIT_PARITY_EN to add a registered digit_parity
// output, which holds the XOR of all bits of digit_out.
module digit_sequence_tx #(
    parameter int                   N       = 4,
    parameter int                   SEQ_LEN = 8,
    parameter logic [SEQ_LEN*N-1:0] CODE    = 32'h8244_4300,
    parameter int                   GAP     = 0
) (
    input  logic         clk,
    input  logic         asyn_n_rst,
    input  logic         start,
    input  logic         abort,
    input  logic         digit_ready,
    output logic [N-1:0] digit_out,
    output logic         digit_valid,
    output logic         busy,
    output logic         done
`ifdef DIGIT_PARITY_EN
    ,
    output logic         digit_parity
`endif
);

    localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int CNT_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] gap_cnt;

    logic             abort_act;
    logic             handshake;
    logic             load_en;
    logic [IDX_W-1:0] load_idx;
    logic [N-1:0]     load_digit;

    // Returns digit i of the stored code. Digit 0 is in the low bits.
    function automatic logic [N-1:0] code_digit(input logic [IDX_W-1:0] i);
        return CODE[int'(i)*N +: N];
    endfunction

    // Work out when the digit register takes a new code digit, and which one.
    // An abort suppresses the load, so the digit in flight counts as not sent.
    always_comb begin
        abort_act = abort && (state != S_IDLE);
        handshake = (state == S_SEND) && digit_valid && digit_ready;
        load_en   = 1'b0;
        load_idx  = '0;
        case (state)
            S_IDLE:  load_en = start;
            S_SEND:  load_en = handshake && (idx != LAST_IDX) && (GAP == 0);
            S_GAP:   load_en = (gap_cnt == CNT_ONE);
            default: load_en = 1'b0;
        endcase
        if (state != S_IDLE) begin
            load_idx = idx + 1'b1;
        end
        if (abort_act) begin
            load_en = 1'b0;
        end
        load_digit = code_digit(load_idx);
    end

    // Sequencer: control state, digit index, gap counter and the valid, busy
    // and done outputs.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            gap_cnt     <= '0;
            digit_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_act) begin
                state       <= S_IDLE;
                idx         <= '0;
                gap_cnt     <= '0;
                digit_valid <= 1'b0;
                busy        <= 1'b0;
            end else begin
                if (load_en) begin
                    idx <= load_idx;
                end
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state       <= S_SEND;
                            digit_valid <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                    S_SEND: begin
                        if (handshake) begin
                            if (idx == LAST_IDX) begin
                                state       <= S_DONE;
                                digit_valid <= 1'b0;
                                done        <= 1'b1;
                            end else if (GAP > 0) begin
                                state       <= S_GAP;
                                gap_cnt     <= GAP_LOAD;
                                digit_valid <= 1'b0;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == CNT_ONE) begin
                            state       <= S_SEND;
                            gap_cnt     <= '0;
                            digit_valid <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state       <= S_IDLE;
                        digit_valid <= 1'b0;
                        busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef DIGIT_PARITY_EN
    // Digit register and its parity. Both load together, so they always
    // describe the same digit.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            digit_out    <= '0;
            digit_parity <= 1'b0;
        end else if (load_en) begin
            digit_out    <= load_digit;
            digit_parity <= ^load_digit;
        end
    end
`else
    // Digit register. It holds its value between loads, which keeps the digit
    // stable while the sink is not ready.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            digit_out <= '0;
        end else if (load_en) begin
            digit_out <= load_digit;
        end
    end
`endif

endmodule

// File: tb/tb_digit_sequence_tx.sv
// Directed testbench for digit_sequence_tx.
// One instance uses the default parameters; a second instance uses GAP=2.
// When DIGIT_PARITY_EN is defined, the parity output is also checked.
module tb_digit_sequence_tx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ready = 1'b1;
    logic [3:0] dout;
    logic       vld;
    logic       busy;
    logic       done;

    logic       start_g = 1'b0;
    logic       abort_g = 1'b0;
    logic       ready_g = 1'b1;
    logic [3:0] dout_g;
    logic       vld_g;
    logic       busy_g;
    logic       done_g;
`ifdef DIGIT_PARITY_EN
    logic       par;
    logic       par_g;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] exp_d [8] = '{4'd0, 4'd0, 4'd3, 4'd4, 4'd4, 4'd4, 4'd2, 4'd8};
    logic       exp_p [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    digit_sequence_tx dut (
        .clk         (clk),
        .asyn_n_rst  (rst_n),
        .start       (start),
        .abort       (abort),
        .digit_ready (ready),
        .digit_out   (dout),
        .digit_valid (vld),
        .busy        (busy),
        .done        (done)
`ifdef DIGIT_PARITY_EN
        ,
        .digit_parity(par)
`endif
    );

    digit_sequence_tx #(.GAP(2)) dut_gap (
        .clk         (clk),
        .asyn_n_rst  (rst_n),
        .start       (start_g),
        .abort       (abort_g),
        .digit_ready (ready_g),
        .digit_out   (dout_g),
        .digit_valid (vld_g),
        .busy        (busy_g),
        .done        (done_g)
`ifdef DIGIT_PARITY_EN
        ,
        .digit_parity(par_g)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset values
        #2 rst_n = 1'b0;
        tick();
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_gap_valid", 32'(vld_g), 32'd0);
`ifdef DIGIT_PARITY_EN
        chk("rst_parity", 32'(par), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // basic sequence with ready tied high
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_valid%0d", i), 32'(vld), 32'd1);
            chk($sformatf("t1_digit%0d", i), 32'(dout), 32'(exp_d[i]));
            chk($sformatf("t1_busy%0d", i), 32'(busy), 32'd1);
            chk($sformatf("t1_done%0d", i), 32'(done), 32'd0);
`ifdef DIGIT_PARITY_EN
            chk($sformatf("t1_parity%0d", i), 32'(par), 32'(exp_p[i]));
`endif
            tick();
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_valid", 32'(vld), 32'd0);
        chk("t1_done_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_after_done", 32'(done), 32'd0);
        chk("t1_after_busy", 32'(busy), 32'd0);

        // backpressure: digit 3 is held for 4 cycles
        begin
            logic [3:0] bp_d [11] = '{4'd0, 4'd0, 4'd3, 4'd3, 4'd3, 4'd3,
                                      4'd4, 4'd4, 4'd4, 4'd2, 4'd8};
            logic       bp_r [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                      1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 0; c < 11; c++) begin
                ready = bp_r[c];
                chk($sformatf("bp_valid%0d", c), 32'(vld), 32'd1);
                chk($sformatf("bp_digit%0d", c), 32'(dout), 32'(bp_d[c]));
                tick();
            end
            ready = 1'b1;
            chk("bp_done", 32'(done), 32'd1);
            tick();
            chk("bp_after_busy", 32'(busy), 32'd0);
        end

        // GAP=2 instance: one valid cycle, then two idle cycles
        start_g = 1'b1;
        tick();
        start_g = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            if ((c - 1) % 3 == 0) begin
                chk($sformatf("gap_valid%0d", c), 32'(vld_g), 32'd1);
                chk($sformatf("gap_digit%0d", c), 32'(dout_g), 32'(exp_d[(c - 1) / 3]));
            end else begin
                chk($sformatf("gap_idle%0d", c), 32'(vld_g), 32'd0);
            end
            chk($sformatf("gap_busy%0d", c), 32'(busy_g), 32'd1);
            chk($sformatf("gap_nodone%0d", c), 32'(done_g), 32'd0);
            tick();
        end
        chk("gap_done", 32'(done_g), 32'd1);
        chk("gap_done_valid", 32'(vld_g), 32'd0);
        tick();
        chk("gap_after_busy", 32'(busy_g), 32'd0);

        // abort while idx=5, in the same cycle as a handshake
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ab_digit%0d", i), 32'(dout), 32'(exp_d[i]));
            if (i < 5) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid", 32'(vld), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("ab_nodone%0d", c), 32'(done), 32'd0);
            chk($sformatf("ab_idle_busy%0d", c), 32'(busy), 32'd0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle_abort_busy", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_restart_valid", 32'(vld), 32'd1);
        chk("ab_restart_digit", 32'(dout), 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("ab_re_digit%0d", i), 32'(dout), 32'(exp_d[i]));
        end
        tick();
        chk("ab_re_done", 32'(done), 32'd1);
        tick();

        // start held high: one idle cycle between sequences
        start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("sh_digit%0d", i), 32'(dout), 32'(exp_d[i]));
            chk($sformatf("sh_valid%0d", i), 32'(vld), 32'd1);
            tick();
        end
        chk("sh_done", 32'(done), 32'd1);
        tick();
        chk("sh_idle_busy", 32'(busy), 32'd0);
        chk("sh_idle_valid", 32'(vld), 32'd0);
        chk("sh_idle_done", 32'(done), 32'd0);
        tick();
        start = 1'b0;
        chk("sh_second_valid", 32'(vld), 32'd1);
        chk("sh_second_digit", 32'(dout), 32'd0);
        chk("sh_second_busy", 32'(busy), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("sh2_digit%0d", i), 32'(dout), 32'(exp_d[i]));
        end
        tick();
        chk("sh2_done", 32'(done), 32'd1);
        tick();
        chk("sh2_busy", 32'(busy), 32'd0);

        // asynchronous reset between clock edges in the middle of a sequence
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ar_pre_digit", 32'(dout), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_dout", 32'(dout), 32'd0);
        chk("ar_valid", 32'(vld), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
`ifdef DIGIT_PARITY_EN
        chk("ar_parity", 32'(par), 32'd0);
`endif
        #3 rst_n = 1'b1;
        tick();
        chk("ar_post_busy", 32'(busy), 32'd0);
        chk("ar_post_done", 32'(done), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ar_restart_digit", 32'(dout), 32'd0);
        chk("ar_restart_valid", 32'(vld), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
